riscv_dcache_sa: RTL
====================

Name: riscv_dcache_sa

Overview:
- Parametrised set-associative data cache between the pipeline MEM stage and data memory.
- Replaces the fixed 4-line, single-word, zero-latency direct-mapped cache.
- Adds multi-word lines, 1 or 2 ways with LRU replacement, and a real miss path (refill FSM over a ready/valid memory port).
- Write-through with write-update on hit and no-write-allocate; also provides flush and hit/miss counters.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, word width (fixed at 32; byte offset is 2 bits)
- SETS, 4, number of sets (power of 2, >=2)
- WORDS, 4, words per line (power of 2, >=1)
- WAYS, 2, associativity (1 or 2)

Ports:
- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- req_valid  in  1  CPU request valid
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address; bits [1:0] ignored
- req_wdata  in  DATA_W  store data
- req_ready  out  1  cache can accept a request this cycle
- rsp_valid  out  1  one-cycle pulse: load data or store ack
- rsp_rdata  out  DATA_W  load data; 0 for store ack
- flush  in  1  invalidate all lines
- mem_req_valid  out  1  memory request valid
- mem_req_write  out  1  memory write
- mem_req_addr  out  ADDR_W  word-aligned byte address
- mem_req_wdata  out  DATA_W  memory write data
- mem_req_ready  in  1  memory accepts the request
- mem_rsp_valid  in  1  read data valid (reads only)
- mem_rsp_rdata  in  DATA_W  read data
- hit_count  out  32  load/store hits, wraps
- miss_count  out  32  load/store misses, wraps

Behaviour:
- Address split: offset = addr[log2(WORDS)+1:2]; index = next log2(SETS) bits; tag = remaining upper bits.
- Reset (async): all valid bits and LRU bits cleared, FSM to IDLE, counters 0.
  - rsp_valid = 0, rsp_rdata = 0, mem_req_valid = 0, mem_req_write = 0, mem_req_addr = 0, mem_req_wdata = 0.
  - Reset mid-refill discards the partial line; a late mem_rsp_valid after reset is ignored.
- req_ready = (state==IDLE) && !flush. A request is accepted on req_valid && req_ready; addr, wdata and write are latched.
- flush in IDLE clears all valid and LRU bits in one cycle and has priority over req. flush outside IDLE is ignored.
- FSM states: IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, WRITE, RESP.
- IDLE -> LOOKUP on accept. Tag compare occurs in LOOKUP against all ways of the indexed set.
- Load hit: LOOKUP -> RESP, with rsp_valid and data driven in the RESP cycle. Latency is 2 cycles from accept. LRU points to the other way. hit_count +1.
- Load miss: miss_count +1; victim = first invalid way (way 0 first), else the LRU way.
  - REFILL_REQ issues reads at line base + 4*k, k = 0..WORDS-1, one outstanding at a time.
  - mem_req_valid is held with stable address until mem_req_ready; then -> REFILL_WAIT.
  - On mem_rsp_valid the word is stored in victim word k. If k < WORDS-1, k+1 -> REFILL_REQ.
  - After the last word: set tag and valid, update LRU, -> RESP returning the requested word.
  - The victim line is invalidated when the refill starts.
- Store: LOOKUP -> WRITE. mem_req_valid=1, write=1, addr, wdata held until mem_req_ready, then -> RESP with rsp_valid=1, rsp_rdata=0.
  - On hit, the cached word is updated in the same cycle the memory accepts; hit_count +1 and LRU updated.
  - On miss, no allocation; miss_count +1.
- RESP lasts one cycle -> IDLE. A new request can be accepted the following cycle.
- WAYS=1: LRU unused; the victim is always way 0.
- Counters wrap from 0xFFFFFFFF to 0.
- mem_req_valid is never deasserted before mem_req_ready. mem_rsp_valid outside REFILL_WAIT is ignored.

Test Plan:
- Reset, then load 0x40 (mem[0x40..0x4C]=0xA0..0xA3, WORDS=4) -> 4 memory reads at 0x40,0x44,0x48,0x4C; rsp_rdata=0xA0; miss_count=1. Load 0x48 -> 2-cycle hit, rsp_rdata=0xA2, hit_count=1, no mem traffic.
- WAYS=2, SETS=4: load 0x000, 0x040, 0x080 (same set). Accesses 0x000 then 0x040; loading 0x080 evicts way holding 0x000 (LRU). Reload 0x040 -> hit; reload 0x000 -> miss.
- Store 0x48 data 0x1234 after line 0x40 is cached -> memory write at 0x48 with 0x1234; subsequent load 0x48 hits returning 0x1234. Store to uncached 0x200 -> write issued, later load 0x200 misses.
- mem_req_ready held low 5 cycles during refill -> mem_req_addr/valid stable for all 5 cycles; req_ready=0 throughout; correct data after release.
- Flush asserted with req_valid in IDLE -> req_ready=0, all lines invalid; repeat load 0x48 -> miss. Flush during REFILL_WAIT -> ignored, refill completes.
- Reset asserted after 2 of 4 refill words -> outputs at reset values immediately; late mem_rsp_valid ignored; load 0x40 -> full 4-word refill.

Source files
------------

// File: rtl/riscv_dcache_sa.sv
// Set-associative write-through data cache (1 or 2 ways, multi-word lines, LRU)
// sitting between the MEM stage and a ready/valid data memory port.
module riscv_dcache_sa #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned SETS   = 4,
   parameter int unsigned WORDS  = 4,
   parameter int unsigned WAYS   = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   input  logic              flush,
   output logic              mem_req_valid,
   output logic              mem_req_write,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [DATA_W-1:0] mem_req_wdata,
   input  logic              mem_req_ready,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rsp_rdata,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
);
   localparam int unsigned OFF_B = $clog2(WORDS);
   localparam int unsigned IDX_B = $clog2(SETS);
   localparam int unsigned OFF_W = (OFF_B == 0) ? 1 : OFF_B;
   localparam int unsigned TAG_W = ADDR_W - 2 - OFF_B - IDX_B;

   typedef enum logic [2:0] {IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, WRITE, RESP} state_t;
   state_t state;

   logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
   logic [DATA_W-1:0] data_mem [WAYS][SETS][WORDS];
   logic [SETS-1:0]   valid    [WAYS];
   logic [SETS-1:0]   lru;     // per set: the least recently used way

   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] wdata_r;
   logic              write_r;
   logic [OFF_W-1:0]  k_r;
   logic              way_r;
   logic              hit_r;

   logic [OFF_W-1:0]  off;
   logic [IDX_B-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic [ADDR_W-1:0] line_base;
   logic              hit, hit_way, victim, last_word;

   assign off       = OFF_W'((addr_r >> 2) & ADDR_W'(WORDS - 1));
   assign idx       = IDX_B'(addr_r >> (2 + OFF_B));
   assign tag       = TAG_W'(addr_r >> (2 + OFF_B + IDX_B));
   assign line_base = addr_r & ~ADDR_W'(4 * WORDS - 1);
   assign last_word = (k_r == OFF_W'(WORDS - 1));
   assign req_ready = (state == IDLE) && !flush;

   // Victim is the lowest-numbered invalid way, otherwise the LRU way.
   always_comb begin
      hit     = 1'b0;
      hit_way = 1'b0;
      victim  = (WAYS > 1) ? lru[idx] : 1'b0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (valid[w[0]][idx] && (tag_mem[w[0]][idx] == tag)) begin
            hit     = 1'b1;
            hit_way = w[0];
         end
      end
      for (int unsigned w = WAYS; w > 0; w--) begin
         if (!valid[1'(w - 1)][idx]) victim = 1'(w - 1);
      end
   end

   always_ff @(posedge clock) begin
      if (state == REFILL_WAIT && mem_rsp_valid) begin
         data_mem[way_r][idx][k_r] <= mem_rsp_rdata;
         if (last_word) tag_mem[way_r][idx] <= tag;
      end
      if (state == WRITE && mem_req_ready && hit_r)
         data_mem[way_r][idx][off] <= wdata_r;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         valid         <= '{default: '0};
         lru           <= '0;
         hit_count     <= '0;
         miss_count    <= '0;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= '0;
         mem_req_valid <= 1'b0;
         mem_req_write <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_wdata <= '0;
         addr_r        <= '0;
         wdata_r       <= '0;
         write_r       <= 1'b0;
         k_r           <= '0;
         way_r         <= 1'b0;
         hit_r         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (flush) begin
                  valid <= '{default: '0};
                  lru   <= '0;
               end else if (req_valid) begin
                  addr_r  <= req_addr;
                  wdata_r <= req_wdata;
                  write_r <= req_write;
                  state   <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (hit) hit_count  <= hit_count + 32'd1;
               else     miss_count <= miss_count + 32'd1;
               if (write_r) begin
                  hit_r         <= hit;
                  way_r         <= hit_way;
                  mem_req_valid <= 1'b1;
                  mem_req_write <= 1'b1;
                  mem_req_addr  <= addr_r & ~ADDR_W'(3);
                  mem_req_wdata <= wdata_r;
                  state         <= WRITE;
               end else if (hit) begin
                  lru[idx]  <= (WAYS > 1) ? ~hit_way : 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= data_mem[hit_way][idx][off];
                  state     <= RESP;
               end else begin
                  way_r              <= victim;
                  valid[victim][idx] <= 1'b0;
                  k_r                <= '0;
                  mem_req_valid      <= 1'b1;
                  mem_req_write      <= 1'b0;
                  mem_req_addr       <= line_base;
                  state              <= REFILL_REQ;
               end
            end
            REFILL_REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  state         <= REFILL_WAIT;
               end
            end
            REFILL_WAIT: begin
               if (mem_rsp_valid) begin
                  if (last_word) begin
                     valid[way_r][idx] <= 1'b1;
                     lru[idx]          <= (WAYS > 1) ? ~way_r : 1'b0;
                     rsp_valid         <= 1'b1;
                     // The requested word may be the one arriving right now.
                     rsp_rdata         <= (k_r == off) ? mem_rsp_rdata : data_mem[way_r][idx][off];
                     state             <= RESP;
                  end else begin
                     k_r           <= k_r + 1'b1;
                     mem_req_valid <= 1'b1;
                     mem_req_addr  <= line_base + (ADDR_W'(k_r + 1'b1) << 2);
                     state         <= REFILL_REQ;
                  end
               end
            end
            WRITE: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  mem_req_write <= 1'b0;
                  if (hit_r) lru[idx] <= (WAYS > 1) ? ~way_r : 1'b0;
                  rsp_valid     <= 1'b1;
                  rsp_rdata     <= '0;
                  state         <= RESP;
               end
            end
            RESP: begin
               rsp_valid <= 1'b0;
               rsp_rdata <= '0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
